// File: rtl/jpeg_ff_stuffer.sv
// jpeg_ff_stuffer: JPEG byte-stuffing stage after the luma Huffman encoder.
// Expands every 0xFF data byte into 0xFF 0x00 and repacks the result into 32-bit
// words. At end of file it pads the last byte with 1s and flushes the partial word.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   data_ready_in  JPEG_in holds a full 32-bit word
//   JPEG_in        packed bitstream word, MSB first (byte 0 = [31:24])
//   eof_in         end-of-file pulse, JPEG_in holds the final partial word
//   eof_bits       valid MSB bits of JPEG_in on the eof_in cycle (0..31)
//   JPEG_out       stuffed output word, MSB first
//   data_ready_out one-cycle strobe, JPEG_out valid
//   out_bytes      valid left-justified bytes in JPEG_out (4, or 0..3 on the final word)
//   eof_out        one-cycle strobe marking the final output of a file
//   overflow       sticky, an input word was dropped for lack of buffer space
module jpeg_ff_stuffer #(
  parameter int unsigned DEPTH_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ready_in,
  input  logic [31:0] JPEG_in,
  input  logic        eof_in,
  input  logic [4:0]  eof_bits,
  output logic [31:0] JPEG_out,
  output logic        data_ready_out,
  output logic [2:0]  out_bytes,
  output logic        eof_out,
  output logic        overflow
);

  // Count must hold DEPTH_BYTES plus a worst-case 8-byte append before the fit check.
  localparam int unsigned CW = $clog2(DEPTH_BYTES + 9);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    buf_q     [DEPTH_BYTES];
  logic [7:0]    buf_d     [DEPTH_BYTES];
  logic [7:0]    buf_shift [DEPTH_BYTES];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic [31:0] src_word;
  logic [2:0]  src_bytes;
  logic [7:0]  exp_bytes [8];
  logic [3:0]  exp_cnt;
  logic [7:0]  cur_byte;

  logic          pop;
  logic          app_req;
  logic          fits;
  logic          accept;
  logic          final_out;
  logic [CW-1:0] base;
  logic [CW-1:0] app_n;
  logic [CW-1:0] fill;

  logic [31:0] jpeg_d;
  logic        dr_d;
  logic        eof_d;
  logic        ovf_d;
  logic [2:0]  ob_d;

  // Input expansion: pad the partial eof word with 1s below eof_bits, then stuff 0x00 after each 0xFF.
  always_comb begin
    src_word  = JPEG_in;
    src_bytes = 3'd4;
    if (eof_in) begin
      src_word  = JPEG_in | (32'hFFFF_FFFF >> eof_bits);
      src_bytes = 3'((6'(eof_bits) + 6'd7) >> 3);
    end
    exp_cnt  = 4'd0;
    cur_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_bytes[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      cur_byte = src_word[31 - 8*i -: 8];
      if (3'(i) < src_bytes) begin
        exp_bytes[exp_cnt[2:0]] = cur_byte;
        exp_cnt                 = exp_cnt + 4'd1;
        if (cur_byte == 8'hFF) begin
          exp_bytes[exp_cnt[2:0]] = 8'h00;
          exp_cnt                 = exp_cnt + 4'd1;
        end
      end
    end
  end

  // Pop/append bookkeeping; the fit check uses the count after this edge's pop.
  always_comb begin
    pop       = count_q >= CW'(4);
    base      = pop ? (count_q - CW'(4)) : count_q;
    app_req   = (state == RUN) && (eof_in || data_ready_in);
    app_n     = app_req ? CW'(exp_cnt) : '0;
    fill      = base + app_n;
    fits      = fill <= CW'(DEPTH_BYTES);
    accept    = app_req && fits;
    final_out = (state == FLUSH) && !pop;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (eof_in) state_nxt = FLUSH;
      FLUSH:   if (!pop)   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output and count next values.
  always_comb begin
    jpeg_d  = JPEG_out;
    dr_d    = 1'b0;
    eof_d   = 1'b0;
    ob_d    = out_bytes;
    ovf_d   = overflow | (app_req && !fits);
    count_d = accept ? fill : base;
    if (pop) begin
      jpeg_d = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
      dr_d   = 1'b1;
      ob_d   = 3'd4;
    end else if (final_out) begin
      // Remaining 0..3 bytes left-justified, unused low bytes zero.
      jpeg_d = 32'h0;
      for (int k = 0; k < 3; k++) begin
        if (CW'(k) < count_q) begin
          jpeg_d[31 - 8*k -: 8] = buf_q[k];
        end
      end
      ob_d    = 3'(count_q);
      eof_d   = 1'b1;
      dr_d    = (count_q != '0);
      count_d = '0;
    end
  end

  // Buffer next contents: shift out the popped word, then place the expansion at the new tail.
  always_comb begin
    for (int j = 0; j < int'(DEPTH_BYTES) - 4; j++) begin
      buf_shift[j] = buf_q[j + 4];
    end
    for (int j = int'(DEPTH_BYTES) - 4; j < int'(DEPTH_BYTES); j++) begin
      buf_shift[j] = 8'h00;
    end
    for (int j = 0; j < int'(DEPTH_BYTES); j++) begin
      buf_d[j] = pop ? buf_shift[j] : buf_q[j];
      if (accept && (CW'(j) >= base) && (CW'(j) < fill)) begin
        buf_d[j] = exp_bytes[3'(CW'(j) - base)];
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      JPEG_out       <= 32'h0;
      data_ready_out <= 1'b0;
      out_bytes      <= 3'd0;
      eof_out        <= 1'b0;
      overflow       <= 1'b0;
      for (int j = 0; j < int'(DEPTH_BYTES); j++) begin
        buf_q[j] <= 8'h00;
      end
    end else begin
      count_q        <= count_d;
      JPEG_out       <= jpeg_d;
      data_ready_out <= dr_d;
      out_bytes      <= ob_d;
      eof_out        <= eof_d;
      overflow       <= ovf_d;
      for (int j = 0; j < int'(DEPTH_BYTES); j++) begin
        buf_q[j] <= buf_d[j];
      end
    end
  end

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Testbench for jpeg_ff_stuffer: byte-queue reference model feeding a timed scoreboard,
// plus fixed expectations for the documented example streams.
module tb_jpeg_ff_stuffer;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready_in = 1'b0;
  logic [31:0] JPEG_in = 32'h0;
  logic        eof_in = 1'b0;
  logic [4:0]  eof_bits = 5'd0;
  logic [31:0] JPEG_out;
  logic        data_ready_out;
  logic [2:0]  out_bytes;
  logic        eof_out;
  logic        overflow;

  jpeg_ff_stuffer #(.DEPTH_BYTES(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_ready_in  (data_ready_in),
    .JPEG_in        (JPEG_in),
    .eof_in         (eof_in),
    .eof_bits       (eof_bits),
    .JPEG_out       (JPEG_out),
    .data_ready_out (data_ready_out),
    .out_bytes      (out_bytes),
    .eof_out        (eof_out),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;
  logic        armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  nb;
    logic        dr;
    logic        eof;
    int          at;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  logic       m_flush = 1'b0;
  logic       m_ovf   = 1'b0;

  logic [31:0] got_w[$];
  logic [2:0]  got_nb[$];
  logic        got_eof[$];

  // Output monitor: compares each strobe against the scoreboard entry due this cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (armed) begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
        e = sb.pop_front();
        total++;
        if (data_ready_out !== e.dr || eof_out !== e.eof || JPEG_out !== e.w || out_bytes !== e.nb) begin
          bad++;
          $display("FAIL out_word cyc=%0d got w=%h nb=%0d dr=%b eof=%b want w=%h nb=%0d dr=%b eof=%b",
                   cyc, JPEG_out, out_bytes, data_ready_out, eof_out, e.w, e.nb, e.dr, e.eof);
        end
      end else if (data_ready_out !== 1'b0 || eof_out !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL spurious_out cyc=%0d got w=%h dr=%b eof=%b want no strobe",
                 cyc, JPEG_out, data_ready_out, eof_out);
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++;
        $display("FAIL overflow_flag cyc=%0d got %b want %b", cyc, overflow, m_ovf);
      end
      if (data_ready_out === 1'b1 || eof_out === 1'b1) begin
        got_w.push_back(JPEG_out);
        got_nb.push_back(out_bytes);
        got_eof.push_back(eof_out);
      end
    end
  end

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input logic r, input logic dr, input logic [31:0] w,
                      input logic e, input logic [4:0] bits);
    logic [7:0]  ex[$];
    logic [31:0] pw;
    logic [31:0] ow;
    logic [7:0]  b;
    logic        was_flush;
    int          nb;
    rst = r; data_ready_in = dr; JPEG_in = w; eof_in = e; eof_bits = bits;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_flush = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      was_flush = m_flush;
      if (mq.size() >= 4) begin
        ow = {mq[0], mq[1], mq[2], mq[3]};
        repeat (4) mq.delete(0);
        sb.push_back('{ow, 3'd4, 1'b1, 1'b0, cyc});
      end else if (was_flush) begin
        ow = 32'h0;
        for (int k = 0; k < mq.size(); k++) ow[31 - 8*k -: 8] = mq[k];
        sb.push_back('{ow, 3'(mq.size()), (mq.size() > 0), 1'b1, cyc});
        mq.delete();
        m_flush = 1'b0;
      end
      if (!was_flush && (e || dr)) begin
        if (e) begin
          nb = (int'(bits) + 7) / 8;
          pw = w | 32'((64'd1 << (32 - int'(bits))) - 64'd1);
        end else begin
          nb = 4;
          pw = w;
        end
        for (int k = 0; k < nb; k++) begin
          b = pw[31 - 8*k -: 8];
          ex.push_back(b);
          if (b == 8'hFF) ex.push_back(8'h00);
        end
        if (mq.size() + ex.size() > DEPTH) m_ovf = 1'b1;
        else foreach (ex[k]) mq.push_back(ex[k]);
      end
      if (!was_flush && e) m_flush = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic clear_log();
    got_w.delete(); got_nb.delete(); got_eof.delete();
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0);
    total++;
    if ({JPEG_out, data_ready_out, out_bytes, eof_out, overflow} !== 38'd0) begin
      bad++;
      $display("FAIL reset_values got w=%h dr=%b nb=%0d eof=%b ovf=%b want all zero",
               JPEG_out, data_ready_out, out_bytes, eof_out, overflow);
    end
    armed = 1'b1;
  endtask

  task automatic test_plain();
    clear_log();
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0);
    total++;
    if (data_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL plain_early got dr=%b want 0", data_ready_out);
    end
    idle(1);
    total++;
    if (data_ready_out !== 1'b1 || JPEG_out !== 32'h1234_5678 || out_bytes !== 3'd4) begin
      bad++;
      $display("FAIL plain_latency got dr=%b w=%h nb=%0d want 1 12345678 4",
               data_ready_out, JPEG_out, out_bytes);
    end
    idle(3);
    total++;
    if (got_w.size() != 1) begin
      bad++;
      $display("FAIL plain_count got %0d words want 1", got_w.size());
    end
  endtask

  task automatic test_all_ff();
    clear_log();
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0);
    idle(4);
    total++;
    if (got_w.size() != 2 || got_w[0] !== 32'hFF00_FF00 || got_w[1] !== 32'hFF00_FF00) begin
      bad++;
      $display("FAIL all_ff got n=%0d w0=%h want 2 x ff00ff00", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'h0);
    end
  endtask

  task automatic test_stuffing();
    clear_log();
    step(1'b0, 1'b1, 32'h12FF_3456, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'hABCD_EF01, 1'b0, 5'd0);
    idle(3);
    total++;
    if (got_w.size() != 2 || got_w[0] !== 32'h12FF_0034 || got_w[1] !== 32'h56AB_CDEF) begin
      bad++;
      $display("FAIL stuffing got n=%0d w0=%h want 12ff0034 56abcdef", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'h0);
    end
  endtask

  // Buffer still holds 0x01 from the stuffing test; flush-state inputs must be ignored.
  task automatic test_eof_pad();
    clear_log();
    step(1'b0, 1'b1, 32'hABC0_0000, 1'b1, 5'd12);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd8);
    idle(3);
    total++;
    if (got_w.size() != 1 || got_w[0] !== 32'h01AB_CF00 || got_nb[0] !== 3'd3 || got_eof[0] !== 1'b1) begin
      bad++;
      $display("FAIL eof_pad got n=%0d w=%h nb=%0d want 01abcf00 nb=3 eof", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'h0, (got_nb.size() > 0) ? got_nb[0] : 3'd0);
    end
  endtask

  task automatic test_eof_ff_pad();
    clear_log();
    step(1'b0, 1'b0, 32'hF000_0000, 1'b1, 5'd4);
    idle(3);
    total++;
    if (got_w.size() != 1 || got_w[0] !== 32'hFF00_0000 || got_nb[0] !== 3'd2) begin
      bad++;
      $display("FAIL eof_ff_pad got n=%0d w=%h nb=%0d want ff000000 nb=2", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'h0, (got_nb.size() > 0) ? got_nb[0] : 3'd0);
    end
    clear_log();
    step(1'b0, 1'b0, 32'h0, 1'b1, 5'd0);
    idle(3);
    total++;
    if (got_w.size() != 1 || got_nb[0] !== 3'd0 || got_eof[0] !== 1'b1) begin
      bad++;
      $display("FAIL eof_empty got n=%0d nb=%0d want 1 entry nb=0 eof", got_w.size(),
               (got_nb.size() > 0) ? got_nb[0] : 3'd7);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) w[31 - 8*k -: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(1'b0, 1'($urandom_range(0, 1)), w, 1'b0, 5'd0);
    end
    step(1'b0, 1'b1, 32'($urandom), 1'b1, 5'($urandom_range(1, 31)));
    idle(8);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    clear_log();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set got %b want 1", overflow);
    end
    idle(8);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky got %b want 1", overflow);
    end
    for (int i = 0; i < got_w.size(); i++) begin
      total++;
      if (got_w[i] !== 32'hFF00_FF00) begin
        bad++;
        $display("FAIL overflow_pattern idx=%0d got %h want ff00ff00", i, got_w[i]);
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_reset_mid_flush();
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0);
    step(1'b0, 1'b0, 32'hFFFF_FF00, 1'b1, 5'd24);
    step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    total++;
    if ({JPEG_out, data_ready_out, out_bytes, eof_out, overflow} !== 38'd0) begin
      bad++;
      $display("FAIL midflush_reset got w=%h dr=%b nb=%0d eof=%b ovf=%b want all zero",
               JPEG_out, data_ready_out, out_bytes, eof_out, overflow);
    end
    clear_log();
    idle(5);
    total++;
    if (got_w.size() != 0) begin
      bad++;
      $display("FAIL midflush_no_eof got %0d outputs want 0", got_w.size());
    end
    clear_log();
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0);
    idle(3);
    total++;
    if (got_w.size() != 1 || got_w[0] !== 32'h1234_5678 || got_nb[0] !== 3'd4) begin
      bad++;
      $display("FAIL midflush_after got n=%0d w=%h want 12345678", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_all_ff();
    test_stuffing();
    test_eof_pad();
    test_eof_ff_pad();
    test_back_to_back();
    test_overflow();
    test_reset_mid_flush();
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
